xyolo_ctrl: RTL and testbench

Sequencer that drives the load-control side of the xyolo compute datapath. It issues operand fetches and generates ld_acc, ld_mp, ld_res and ld_nmac, each aligned to the datapath pipeline, for convolution, convolution+maxpool and bypass layers. It sits between the layer configuration registers and the xyolo datapath, and tags each valid flow_out word for the downstream writer.

---
 rtl/xyolo_ctrl_pkg.sv | 26 ++
 rtl/xyolo_ctrl_dly.sv | 39 +++
 rtl/xyolo_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_xyolo_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/xyolo_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// xyolo_ctrl_pkg
// Shared definitions for the xyolo load-control sequencer: FSM state encoding,
// default pipeline latency / maxpool window, and the tag carried down the
// result delay line. Also imported by the datapath testbench.
// -----------------------------------------------------------------------------
package xyolo_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_FIN   = 2'd3
   } state_e;

   localparam int LAT_DEF    = 7;
   localparam int MP_WIN_DEF = 4;

   // last : operand completes an output (ld_res when it emerges)
   // fin  : that output is the final one of the job (closes a partial window)
   typedef struct packed {
      logic last;
      logic fin;
   } tag_t;

endpackage

// File: rtl/xyolo_ctrl_dly.sv
// -----------------------------------------------------------------------------
// xyolo_ctrl_dly
// DEPTH-stage shift register carrying the {last, fin} tag from operand issue to
// the cycle its result reaches the datapath result register.
// Ports:
//   clk, rst  clock, asynchronous active-low clear
//   d         tag presented in the issue cycle
//   q         tag emerging DEPTH cycles later
//   empty     no tag in flight in any stage
// -----------------------------------------------------------------------------
module xyolo_ctrl_dly
   import xyolo_ctrl_pkg::*;
#(
   parameter int DEPTH = LAT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  tag_t d,
   output tag_t q,
   output logic empty
);

   tag_t [DEPTH-1:0] pipe_q, pipe_d;

   always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = d;
      for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) pipe_q <= '0;
      else      pipe_q <= pipe_d;
   end

   assign q     = pipe_q[DEPTH-1];
   assign empty = (pipe_q == '0);

endmodule

// File: rtl/xyolo_ctrl.sv
// -----------------------------------------------------------------------------
// xyolo_ctrl
// Load-control sequencer for the xyolo datapath. Issues operand fetches and
// produces ld_acc / ld_mp / ld_res / ld_nmac aligned to the datapath pipeline
// for convolution, convolution+maxpool and bypass layers.
// Ports:
//   clk, rst                        clock, asynchronous active-low reset
//   run                             start pulse (sampled in IDLE only)
//   ker_size, n_out, maxpool, bypass layer config, latched on run accept
//   rd_en                           operand fetch strobe
//   ld_acc, ld_mp, ld_res, ld_nmac  datapath load controls
//   out_valid                       flow_out holds a final word
//   busy, done                      job status / one-cycle completion pulse
// -----------------------------------------------------------------------------
module xyolo_ctrl
   import xyolo_ctrl_pkg::*;
#(
   parameter int  N_MACS   = 1,
   parameter int  LAT      = LAT_DEF,
   parameter int  ACC_DLY  = 0,
   parameter int  MP_WIN   = MP_WIN_DEF,
   parameter int  CNT_W    = 16,
   localparam int N_MACS_W = ($clog2(N_MACS) == 0) ? 1 : $clog2(N_MACS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic [CNT_W-1:0]    ker_size,
   input  logic [CNT_W-1:0]    n_out,
   input  logic                maxpool,
   input  logic                bypass,
   output logic                rd_en,
   output logic                ld_acc,
   output logic                ld_mp,
   output logic                ld_res,
   output logic [N_MACS_W-1:0] ld_nmac,
   output logic                out_valid,
   output logic                busy,
   output logic                done
);

   localparam int WIN_W = ($clog2(MP_WIN) == 0) ? 1 : $clog2(MP_WIN);

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    ksz_q, ksz_d, nout_q, nout_d;
   logic [CNT_W-1:0]    ker_cnt_q, ker_cnt_d, out_cnt_q, out_cnt_d;
   logic                mp_q, mp_d, byp_q, byp_d;
   logic [N_MACS_W-1:0] lane_q, lane_d, ld_nmac_q, ld_nmac_d;
   logic [WIN_W-1:0]    win_q, win_d;
   logic                rd_en_q, rd_en_d, acc_q, acc_d;
   logic                ov_q, ov_d, busy_q, busy_d, done_q, done_d;
   logic                issue, op_last, out_last, accept, dly_empty;
   tag_t                tag_in, tag_out;

   // Counters describe the operand being issued in the current cycle.
   assign issue    = (state_q == ST_ISSUE);
   assign accept   = (state_q == ST_IDLE) && run;
   assign op_last  = byp_q || (ker_cnt_q == ksz_q - CNT_W'(1));
   assign out_last = (out_cnt_q == nout_q - CNT_W'(1));

   assign tag_in.last = issue && op_last;
   assign tag_in.fin  = issue && op_last && out_last;

   always_comb begin
      state_d   = state_q;
      ksz_d     = ksz_q;
      nout_d    = nout_q;
      mp_d      = mp_q;
      byp_d     = byp_q;
      ker_cnt_d = ker_cnt_q;
      out_cnt_d = out_cnt_q;
      lane_d    = lane_q;
      case (state_q)
         ST_IDLE: begin
            if (run) begin
               ksz_d     = (ker_size == '0) ? CNT_W'(1) : ker_size;
               nout_d    = n_out;
               mp_d      = maxpool;
               byp_d     = bypass;
               ker_cnt_d = '0;
               out_cnt_d = '0;
               lane_d    = '0;
               state_d   = (n_out == '0) ? ST_FIN : ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (op_last && out_last) begin
               state_d = ST_DRAIN;
            end else if (byp_q) begin
               out_cnt_d = out_cnt_q + CNT_W'(1);
               lane_d    = (lane_q == N_MACS_W'(N_MACS-1)) ? '0 : lane_q + N_MACS_W'(1);
            end else if (op_last) begin
               ker_cnt_d = '0;
               out_cnt_d = out_cnt_q + CNT_W'(1);
            end else begin
               ker_cnt_d = ker_cnt_q + CNT_W'(1);
            end
         end
         ST_DRAIN: if (dly_empty) state_d = ST_FIN;
         default:  state_d = ST_IDLE;
      endcase

      // Outputs are registered from next-state values so rd_en / ld_acc line
      // up with the operand the counters will describe next cycle.
      rd_en_d   = (state_d == ST_ISSUE) && (!byp_d || lane_d == '0);
      acc_d     = (state_d == ST_ISSUE) && !byp_d && (ker_cnt_d != '0);
      // Lane select trails the issue cycle by one to meet the bypass register.
      ld_nmac_d = (issue && byp_q) ? lane_q : '0;
      busy_d    = (state_d != ST_IDLE);
      done_d    = (state_d == ST_FIN);

      // Maxpool window tracks results as they emerge from the delay line.
      win_d = win_q;
      if (accept) win_d = '0;
      else if (tag_out.last && mp_q)
         win_d = (win_q == WIN_W'(MP_WIN-1)) ? '0 : win_q + WIN_W'(1);
      ov_d = tag_out.last && (!mp_q || (win_q == WIN_W'(MP_WIN-1)) || tag_out.fin);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         ksz_q     <= '0;
         nout_q    <= '0;
         mp_q      <= 1'b0;
         byp_q     <= 1'b0;
         ker_cnt_q <= '0;
         out_cnt_q <= '0;
         lane_q    <= '0;
         ld_nmac_q <= '0;
         win_q     <= '0;
         rd_en_q   <= 1'b0;
         acc_q     <= 1'b0;
         ov_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ksz_q     <= ksz_d;
         nout_q    <= nout_d;
         mp_q      <= mp_d;
         byp_q     <= byp_d;
         ker_cnt_q <= ker_cnt_d;
         out_cnt_q <= out_cnt_d;
         lane_q    <= lane_d;
         ld_nmac_q <= ld_nmac_d;
         win_q     <= win_d;
         rd_en_q   <= rd_en_d;
         acc_q     <= acc_d;
         ov_q      <= ov_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   xyolo_ctrl_dly #(.DEPTH(LAT)) u_dly (
      .clk   (clk),
      .rst   (rst),
      .d     (tag_in),
      .q     (tag_out),
      .empty (dly_empty)
   );

   generate
      if (ACC_DLY == 0) begin : g_acc_now
         assign ld_acc = acc_q;
      end else begin : g_acc_dly
         logic [ACC_DLY-1:0] acc_pipe_q, acc_pipe_d;
         always_comb acc_pipe_d = (acc_pipe_q << 1) | ACC_DLY'(acc_q);
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) acc_pipe_q <= '0;
            else      acc_pipe_q <= acc_pipe_d;
         end
         assign ld_acc = acc_pipe_q[ACC_DLY-1];
      end
   endgenerate

   assign rd_en     = rd_en_q;
   assign ld_res    = tag_out.last;
   assign ld_mp     = tag_out.last && mp_q && (win_q != '0);
   assign ld_nmac   = ld_nmac_q;
   assign out_valid = ov_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_xyolo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_xyolo_ctrl
// Self-checking bench for xyolo_ctrl. Each job's expected per-cycle output
// trace is built from the layer timing rules and queued when run is driven;
// the trace is popped and compared every cycle, and pulse counts / done cycle
// are compared against hand-derived table constants.
// -----------------------------------------------------------------------------
module tb_xyolo_ctrl;
   import xyolo_ctrl_pkg::*;

   localparam int NM   = 4;
   localparam int LAT  = LAT_DEF;
   localparam int ADLY = 0;
   localparam int MPW  = MP_WIN_DEF;
   localparam int CW   = 16;

   logic          clk = 1'b0, rst = 1'b0, run = 1'b0;
   logic          maxpool = 1'b0, bypass = 1'b0;
   logic [CW-1:0] ker_size = '0, n_out = '0;
   logic          rd_en, ld_acc, ld_mp, ld_res, out_valid, busy, done;
   logic [1:0]    ld_nmac;

   always #5 clk = ~clk;

   xyolo_ctrl #(.N_MACS(NM), .LAT(LAT), .ACC_DLY(ADLY), .MP_WIN(MPW), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .run(run), .ker_size(ker_size), .n_out(n_out),
      .maxpool(maxpool), .bypass(bypass), .rd_en(rd_en), .ld_acc(ld_acc),
      .ld_mp(ld_mp), .ld_res(ld_res), .ld_nmac(ld_nmac), .out_valid(out_valid),
      .busy(busy), .done(done));

   typedef struct packed {
      logic       rd, acc, res, mp, ov, busy, done;
      logic [1:0] nmac;
   } obs_t;

   // {inputs, expected pulse counts and run-to-done cycle}
   typedef struct {
      int k, n, mp, byp;
      int n_rd, n_res, n_ov, t_done;
   } vec_t;

   vec_t vecs[8];
   vec_t hv;
   obs_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic obs_t sample();
      obs_t o;
      o.rd = rd_en; o.acc = ld_acc; o.res = ld_res; o.mp = ld_mp;
      o.ov = out_valid; o.busy = busy; o.done = done; o.nmac = ld_nmac;
      return o;
   endfunction

   task automatic check_obs(input string name, input int t, input obs_t got, input obs_t exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got={rd,acc,res,mp,ov,busy,done,nmac}=%b exp=%b",
                  name, t, got, exp);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic run_job(input int id, input vec_t v, input bit hold);
      int   k, nops, td, nt, o, c_rd, c_res, c_ov, t_seen;
      bit   mp, byp;
      obs_t tl[];
      obs_t g, e;
      string nm;
      nm  = $sformatf("job%0d", id);
      mp  = (v.mp != 0);
      byp = (v.byp != 0);
      k    = (v.k == 0) ? 1 : v.k;
      nops = byp ? v.n : k * v.n;
      td   = (v.n == 0) ? 1 : nops + LAT + 2;
      nt   = td + 2;
      tl   = new[nt];
      foreach (tl[c]) tl[c] = '0;
      for (int c = 1; c <= td; c++) tl[c].busy = 1'b1;
      tl[td].done = 1'b1;
      for (int i = 0; i < nops; i++) begin
         tl[1+i].rd = byp ? (i % NM == 0) : 1'b1;
         if (!byp) tl[1+i+ADLY].acc = (i % k != 0);
         if (byp)  tl[2+i].nmac = 2'(i % NM);
         if (byp || (i % k == k - 1)) begin
            o = byp ? i : i / k;
            tl[1+i+LAT].res = 1'b1;
            tl[1+i+LAT].mp  = mp && (o % MPW != 0);
            if (!mp || (o % MPW == MPW - 1) || (o == v.n - 1)) tl[2+i+LAT].ov = 1'b1;
         end
      end
      foreach (tl[c]) exp_q.push_back(tl[c]);

      c_rd = 0; c_res = 0; c_ov = 0; t_seen = -1;
      for (int c = 0; c < nt; c++) begin
         @(posedge clk); #1;
         run = (c == 0) || (hold && c <= td);
         if (c == 0) begin
            ker_size = CW'(v.k); n_out = CW'(v.n); maxpool = mp; bypass = byp;
         end else begin
            // config is latched at accept; later changes must not matter
            ker_size = CW'($urandom); n_out = CW'($urandom);
            maxpool = 1'($urandom); bypass = 1'($urandom);
         end
         @(negedge clk);
         g = sample();
         e = exp_q.pop_front();
         check_obs(nm, c, g, e);
         c_rd  += int'(g.rd);
         c_res += int'(g.res);
         c_ov  += int'(g.ov);
         if (g.done) t_seen = c;
      end
      run = 1'b0;
      check_int({nm, "_n_rd"},   c_rd,   v.n_rd);
      check_int({nm, "_n_res"},  c_res,  v.n_res);
      check_int({nm, "_n_ov"},   c_ov,   v.n_ov);
      check_int({nm, "_t_done"}, t_seen, v.t_done);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end

   initial begin
      //          k  n mp byp rd res ov done
      vecs[0] = '{9, 3, 0, 0, 27, 3, 3, 36};
      vecs[1] = '{1, 8, 1, 0,  8, 8, 2, 17};
      vecs[2] = '{1, 6, 0, 1,  2, 6, 6, 15};
      vecs[3] = '{3, 0, 0, 0,  0, 0, 0,  1};
      vecs[4] = '{1, 6, 1, 0,  6, 6, 2, 15};
      vecs[5] = '{0, 2, 0, 0,  2, 2, 2, 11};
      vecs[6] = '{2, 5, 1, 0, 10, 5, 2, 19};
      vecs[7] = '{1, 5, 1, 1,  2, 5, 2, 14};
      hv      = '{2, 2, 0, 0,  4, 2, 2, 13};

      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 check_obs("reset", 0, sample(), '0);
      rst = 1'b1;

      for (int j = 0; j < 8; j++) run_job(j, vecs[j], 1'b0);

      // run held high through a whole job: only one job may execute
      run_job(100, hv, 1'b1);

      // reset during ISSUE after 5 operands
      @(posedge clk); #1;
      run = 1'b1; ker_size = 16'd9; n_out = 16'd3; maxpool = 1'b0; bypass = 1'b0;
      @(posedge clk); #1;
      run = 1'b0;
      repeat (5) @(posedge clk);
      #1 check_int("abort_pre_rd", int'(rd_en), 1);
      rst = 1'b0;
      #1 check_obs("abort_out", 0, sample(), '0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check_obs("abort_hold", c, sample(), '0);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check_obs("abort_quiet", c, sample(), '0);
      end
      run_job(101, hv, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
